// File: rtl/csa_tree_pipe.sv
// -----------------------------------------------------------------------------
// csa_tree_pipe
// Pipelined carry-save reduction tree. NUM_IN operands of WIDTH bits are
// reduced to a redundant sum/carry pair by levels of 3:2 compressors, with a
// register stage after every level. An optional carry-propagate stage
// (FINAL_ADD=1) adds the pair into a binary result. All arithmetic wraps
// modulo 2^WIDTH.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset (clears valid, data and tags)
//   flush_i      synchronous kill of every in-flight operation
//   in_valid_i   operand set valid
//   in_ready_o   an operand set can be accepted this cycle
//   ops_i        packed operands, operand k at [k*WIDTH +: WIDTH]
//   in_tag_i     sideband tag travelling with the operation
//   out_valid_o  output valid
//   out_ready_i  downstream accepts the output
//   sum_o        redundant sum
//   carry_o      redundant carry, already weighted by 2
//   result_o     sum_o + carry_o (0 when FINAL_ADD=0)
//   out_tag_o    tag of the operation on the outputs
// -----------------------------------------------------------------------------
module csa_tree_pipe #(
   parameter int NUM_IN    = 6,
   parameter int WIDTH     = 32,
   parameter int TAG_W     = 4,
   parameter int FINAL_ADD = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic [NUM_IN*WIDTH-1:0] ops_i,
   input  logic [TAG_W-1:0]        in_tag_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [WIDTH-1:0]        sum_o,
   output logic [WIDTH-1:0]        carry_o,
   output logic [WIDTH-1:0]        result_o,
   output logic [TAG_W-1:0]        out_tag_o
);

   localparam int MAXN = 8;

   // Operand count after one level: each triple becomes two, leftovers pass.
   function automatic int next_count(input int n);
      return 2 * (n / 3) + (n % 3);
   endfunction

   // Operand count entering level lvl.
   function automatic int count_at(input int lvl);
      int n;
      n = NUM_IN;
      for (int i = 0; i < lvl; i++) n = next_count(n);
      return n;
   endfunction

   // Number of compressor levels needed to reach two operands.
   function automatic int num_levels(input int n0);
      int n;
      int l;
      n = n0;
      l = 0;
      for (int i = 0; i < MAXN; i++) begin
         if (n > 2) begin
            n = next_count(n);
            l = l + 1;
         end else begin
            n = n;
         end
      end
      return l;
   endfunction

   localparam int L = num_levels(NUM_IN);
   localparam int S = L + FINAL_ADD;

   if (NUM_IN < 3 || NUM_IN > 8) begin : g_bad_num_in
      $error("csa_tree_pipe: NUM_IN must be within 3..8");
   end
   if (FINAL_ADD != 0 && FINAL_ADD != 1) begin : g_bad_final_add
      $error("csa_tree_pipe: FINAL_ADD must be 0 or 1");
   end
   if (WIDTH < 2) begin : g_bad_width
      $error("csa_tree_pipe: WIDTH must be at least 2");
   end

   // One level of 3:2 compression over the n live operands of v. Triples
   // from the lowest index produce (sum, weighted carry) pairs; the n mod 3
   // leftovers are appended after them. Unused slots are zero.
   function automatic logic [MAXN*WIDTH-1:0] compress(input logic [MAXN*WIDTH-1:0] v,
                                                      input int n);
      logic [MAXN*WIDTH-1:0] r;
      logic [WIDTH-1:0]      a;
      logic [WIDTH-1:0]      b;
      logic [WIDTH-1:0]      c;
      logic [WIDTH-1:0]      mj;
      int                    t3;
      r  = '0;
      t3 = n / 3;
      for (int t = 0; t < MAXN / 3; t++) begin
         if (t < t3) begin
            a  = v[(3*t)*WIDTH   +: WIDTH];
            b  = v[(3*t+1)*WIDTH +: WIDTH];
            c  = v[(3*t+2)*WIDTH +: WIDTH];
            mj = (a & b) | (a & c) | (b & c);
            r[(2*t)*WIDTH   +: WIDTH] = a ^ b ^ c;
            r[(2*t+1)*WIDTH +: WIDTH] = {mj[WIDTH-2:0], 1'b0};
         end else begin
            r = r;
         end
      end
      for (int p = 0; p < 2; p++) begin
         if (p < n % 3) begin
            r[(2*t3+p)*WIDTH +: WIDTH] = v[(3*t3+p)*WIDTH +: WIDTH];
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Operand idx of a packed level vector.
   function automatic logic [WIDTH-1:0] pick(input logic [MAXN*WIDTH-1:0] v, input int idx);
      return v[idx*WIDTH +: WIDTH];
   endfunction

   logic [MAXN*WIDTH-1:0]   ops_pad_s;
   logic [MAXN*WIDTH-1:0]   lvl_in_s [L];
   logic [MAXN*WIDTH-1:0]   lvl_r    [L];
   logic [S-1:0]            valid_r;
   logic [S-1:0][TAG_W-1:0] tag_r;
   logic [S-1:0]            src_valid_s;
   logic [S-1:0][TAG_W-1:0] src_tag_s;
   logic [S-1:0]            move_s;
   logic [S-1:0]            move_mask_s;
   logic [S-1:0]            load_s;

   // Zero-extend the input operands to the fixed-size level vector.
   always_comb begin
      ops_pad_s = '0;
      ops_pad_s[NUM_IN*WIDTH-1:0] = ops_i;
   end

   // Source of each stage: the input port for stage 0, else the stage before.
   always_comb begin
      src_valid_s    = '0;
      src_tag_s      = '0;
      src_valid_s[0] = in_valid_i;
      src_tag_s[0]   = in_tag_i;
      for (int i = 1; i < S; i++) begin
         src_valid_s[i] = valid_r[i-1];
         src_tag_s[i]   = tag_r[i-1];
      end
   end

   // Stage i moves when out_ready_i is high or some stage at or after i is
   // empty; this is the chained advance rule unrolled so there is no
   // combinational loop through the move vector.
   always_comb begin
      move_s      = '0;
      move_mask_s = '0;
      for (int i = 0; i < S; i++) begin
         for (int k = 0; k < S; k++) begin
            if (k >= i) move_mask_s[k] = 1'b1;
            else        move_mask_s[k] = 1'b0;
         end
         move_s[i] = out_ready_i | ((valid_r & move_mask_s) != move_mask_s);
      end
   end

   // Data and tags only load for a real operation, so idle stages hold and
   // nothing from an empty stage ever reaches a valid one.
   assign load_s     = move_s & src_valid_s & {S{~flush_i}};
   assign in_ready_o = move_s[0];

   for (genvar j = 0; j < L; j++) begin : g_lvl
      if (j == 0) begin : g_first
         assign lvl_in_s[j] = compress(ops_pad_s, NUM_IN);
      end else begin : g_rest
         assign lvl_in_s[j] = compress(lvl_r[j-1], count_at(j));
      end
   end

   // Valid bits: reset and flush empty the pipe, otherwise moving stages
   // take their source's valid and stalled stages hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_r <= '0;
      end else if (flush_i) begin
         valid_r <= '0;
      end else begin
         valid_r <= (move_s & src_valid_s) | (~move_s & valid_r);
      end
   end

   // Tag pipeline, advancing with the data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_r <= '0;
      end else begin
         for (int i = 0; i < S; i++) begin
            if (load_s[i]) tag_r[i] <= src_tag_s[i];
            else           tag_r[i] <= tag_r[i];
         end
      end
   end

   // Compressor level registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int j = 0; j < L; j++) lvl_r[j] <= '0;
      end else begin
         for (int j = 0; j < L; j++) begin
            if (load_s[j]) lvl_r[j] <= lvl_in_s[j];
            else           lvl_r[j] <= lvl_r[j];
         end
      end
   end

   if (FINAL_ADD != 0) begin : g_final
      logic [WIDTH-1:0] fsum_r;
      logic [WIDTH-1:0] fcar_r;
      logic [WIDTH-1:0] fres_r;
      logic [WIDTH-1:0] pair_sum_s;
      logic [WIDTH-1:0] pair_car_s;

      assign pair_sum_s = pick(lvl_r[L-1], 0);
      assign pair_car_s = pick(lvl_r[L-1], 1);

      // Carry-propagate stage: keeps the redundant pair alongside the sum.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            fsum_r <= '0;
            fcar_r <= '0;
            fres_r <= '0;
         end else if (load_s[S-1]) begin
            fsum_r <= pair_sum_s;
            fcar_r <= pair_car_s;
            fres_r <= pair_sum_s + pair_car_s;
         end else begin
            fsum_r <= fsum_r;
            fcar_r <= fcar_r;
            fres_r <= fres_r;
         end
      end

      assign sum_o    = fsum_r;
      assign carry_o  = fcar_r;
      assign result_o = fres_r;
   end else begin : g_direct
      assign sum_o    = pick(lvl_r[L-1], 0);
      assign carry_o  = pick(lvl_r[L-1], 1);
      assign result_o = '0;
   end

   assign out_valid_o = valid_r[S-1];
   assign out_tag_o   = tag_r[S-1];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_csa_tree_pipe
// Scoreboard bench: every accepted operation pushes its expected sum and tag
// (plain modular addition of the operands) into a queue; monitors pop and
// compare whenever an output transfer happens. A main DUT (6x32, final add)
// runs directed and random traffic; a set of extra instances sweeps other
// NUM_IN / FINAL_ADD values with random streaming traffic.
// -----------------------------------------------------------------------------
module tb_csa_tree_pipe;

   typedef struct {
      logic [31:0] sum;
      logic [3:0]  tag;
      int          cyc;
   } exp_t;

   localparam int NCFG = 7;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [191:0] ops;
   logic [3:0]   in_tag;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  sum;
   logic [31:0]  carry;
   logic [31:0]  result;
   logic [3:0]   out_tag;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   sweep_done = 0;
   exp_t q[$];
   bit   lat_chk = 1'b0;
   bit   stream_win = 1'b0;
   bit   rand_win = 1'b0;
   bit   ready_low = 1'b0;
   int   n_win = 0;
   int   first_c = 0;
   int   last_c = 0;
   logic [31:0] last_res = 32'd0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   csa_tree_pipe #(.NUM_IN(6), .WIDTH(32), .TAG_W(4), .FINAL_ADD(1)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .ops_i(ops), .in_tag_i(in_tag),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .sum_o(sum),
      .carry_o(carry), .result_o(result), .out_tag_o(out_tag));

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [191:0] rand6();
      logic [191:0] r;
      for (int k = 0; k < 6; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // Offer v until accepted (bounded); optionally record the expected result.
   task automatic send(input logic [191:0] v, input logic [3:0] t, input bit push,
                       output int waited);
      exp_t        e;
      logic [31:0] acc;
      in_valid = 1'b1;
      ops      = v;
      in_tag   = t;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 200) begin
         waited++;
         @(negedge clk);
      end
      chk("accept_bound", in_ready, 1'b1);
      if (in_ready && push) begin
         acc = 32'd0;
         for (int k = 0; k < 6; k++) acc = acc + v[k*32 +: 32];
         e.sum = acc;
         e.tag = t;
         e.cyc = cyc;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int g;
      g = 0;
      while (q.size() != 0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      chk(name, q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard pops on transfers, stability on stalls.
   logic        hold = 1'b0;
   logic [95:0] h_data;
   logic [3:0]  h_tag;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         hold = 1'b0;
         chk("out_expected", q.size() != 0, 1'b1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("result", result, e.sum);
            chk("sum_plus_carry", 32'(sum + carry), e.sum);
            chk("tag", out_tag, e.tag);
            if (lat_chk) chk("latency", cyc - e.cyc, 4);
            last_res = result;
            if (stream_win) begin
               if (n_win == 0) first_c = cyc;
               last_c = cyc;
               n_win++;
            end
         end
      end else if (rst_n && out_valid) begin
         if (hold) begin
            chk("stall_stable", {sum, carry, result}, h_data);
            chk("stall_tag", out_tag, h_tag);
         end
         hold   = 1'b1;
         h_data = {sum, carry, result};
         h_tag  = out_tag;
      end else begin
         hold = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (stream_win && !in_ready) ready_low = 1'b1;
   end

   always @(posedge clk) begin
      #1;
      if (rand_win) out_ready = 1'($urandom);
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      int           w;
      int           g;
      logic [191:0] v;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; ops = '0; in_tag = 4'h0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_data", {sum, carry, result}, 96'd0);
      chk("reset_tag", out_tag, 4'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // basic sum and wrap-around
      lat_chk = 1'b1;
      send({32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 4'hA, 1'b1, w);
      wait_drain("basic_drain");
      chk("basic_result", last_res, 32'd21);
      send({6{32'hFFFF_FFFF}}, 4'h3, 1'b1, w);
      wait_drain("wrap1_drain");
      chk("wrap1_result", last_res, 32'hFFFF_FFFA);
      send({32'd0, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 32'h8000_0000}, 4'h5, 1'b1, w);
      wait_drain("wrap2_drain");
      chk("wrap2_result", last_res, 32'd0);

      // streaming
      stream_win = 1'b1; n_win = 0; ready_low = 1'b0;
      for (int i = 0; i < 10; i++) begin
         v = '0;
         v[31:0] = 32'(i);
         send(v, 4'(i), 1'b1, w);
      end
      wait_drain("stream_drain");
      stream_win = 1'b0;
      chk("stream_count", n_win, 10);
      chk("stream_contig", last_c - first_c, 9);
      chk("stream_ready_low", ready_low, 1'b0);

      // backpressure
      lat_chk = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(rand6(), 4'(i + 1), 1'b1, w);
         chk("bp_accept", w, 0);
      end
      v = rand6();
      in_valid = 1'b1; ops = v; in_tag = 4'hE;
      repeat (3) begin
         @(negedge clk);
         chk("bp_full_ready", in_ready, 1'b0);
         chk("bp_out_valid", out_valid, 1'b1);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      send(v, 4'hE, 1'b1, w);
      chk("bp_same_cycle", w, 0);
      wait_drain("bp_drain");

      // flush with an input offered in the same cycle
      for (int i = 0; i < 3; i++) send(rand6(), 4'(i), 1'b0, w);
      in_valid = 1'b1; ops = rand6(); flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("flush_quiet", out_valid, 1'b0);
      end
      @(posedge clk); #1;
      lat_chk = 1'b1;
      send(rand6(), 4'h9, 1'b1, w);
      wait_drain("flush_recover");

      // reset with operations in flight
      lat_chk = 1'b0;
      send(rand6(), 4'h1, 1'b0, w);
      send(rand6(), 4'h2, 1'b0, w);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_data", {sum, carry, result}, 96'd0);
      chk("rst_tag", out_tag, 4'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // random traffic with random backpressure
      rand_win = 1'b1;
      for (int i = 0; i < 40; i++) send(rand6(), 4'($urandom), 1'b1, w);
      rand_win = 1'b0; out_ready = 1'b1;
      wait_drain("rand_drain");

      g = 0;
      while (sweep_done < NCFG && g < 2000) begin
         @(posedge clk);
         g++;
      end
      chk("sweep_done", sweep_done, NCFG);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // ---------------- configuration sweep ----------------
   function automatic int cfg_n(input int i);
      case (i)
         0: return 3;
         1: return 4;
         2: return 5;
         3: return 7;
         4: return 8;
         5: return 6;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_f(input int i);
      case (i)
         6: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_lat(input int i);
      case (i)
         0: return 1;
         1: return 2;
         2: return 3;
         3: return 4;
         4: return 4;
         5: return 3;
         default: return 5;
      endcase
   endfunction

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_sw
      localparam int N   = cfg_n(gi);
      localparam int F   = cfg_f(gi);
      localparam int LAT = cfg_lat(gi);

      logic            srst_n;
      logic            sv;
      logic            srdy;
      logic            sovld;
      logic [N*16-1:0] sops;
      logic [3:0]      stag;
      logic [3:0]      sotag;
      logic [15:0]     ssum;
      logic [15:0]     scar;
      logic [15:0]     sres;
      exp_t            sq[$];

      csa_tree_pipe #(.NUM_IN(N), .WIDTH(16), .TAG_W(4), .FINAL_ADD(F)) u_sw (
         .clk(clk), .rst_n(srst_n), .flush_i(1'b0), .in_valid_i(sv),
         .in_ready_o(srdy), .ops_i(sops), .in_tag_i(stag),
         .out_valid_o(sovld), .out_ready_i(1'b1), .sum_o(ssum),
         .carry_o(scar), .result_o(sres), .out_tag_o(sotag));

      initial begin
         exp_t        e;
         logic [15:0] acc;
         logic [15:0] r;
         srst_n = 1'b0; sv = 1'b0; sops = '0; stag = 4'h0;
         repeat (3) @(posedge clk);
         #1 srst_n = 1'b1;
         for (int i = 0; i < 25; i++) begin
            acc = 16'd0;
            for (int k = 0; k < N; k++) begin
               r = 16'($urandom);
               sops[k*16 +: 16] = r;
               acc = acc + r;
            end
            stag = 4'($urandom);
            sv   = 1'b1;
            @(negedge clk);
            chk($sformatf("sw%0d_ready", gi), srdy, 1'b1);
            e.sum = {16'd0, acc};
            e.tag = stag;
            e.cyc = cyc;
            sq.push_back(e);
            @(posedge clk);
            #1;
         end
         sv = 1'b0;
         repeat (LAT + 4) @(posedge clk);
         chk($sformatf("sw%0d_drain", gi), sq.size(), 0);
         sweep_done++;
      end

      always @(negedge clk) begin
         exp_t e;
         if (srst_n && sovld) begin
            chk($sformatf("sw%0d_out_expected", gi), sq.size() != 0, 1'b1);
            if (sq.size() != 0) begin
               e = sq.pop_front();
               chk($sformatf("sw%0d_sum_carry", gi), 16'(ssum + scar), e.sum);
               chk($sformatf("sw%0d_result", gi), sres, (F != 0) ? e.sum : 32'd0);
               chk($sformatf("sw%0d_tag", gi), sotag, e.tag);
               chk($sformatf("sw%0d_latency", gi), cyc - e.cyc, LAT);
            end
         end
      end
   end

endmodule

// File: doc/csa_tree_pipe.md
Name: csa_tree_pipe

Overview:
- Parametrised, pipelined carry-save reduction tree for the one-cycle multiplier datapath.
- Reduces NUM_IN operands of WIDTH bits to a redundant sum/carry pair using levels of 3:2 compressors, with a pipeline register after every level.
- An optional final carry-propagate stage produces the binary result.
- A valid/ready handshake with full backpressure and a synchronous flush lets it sit between partial-product generation and the multiplier writeback stage.

Parameters:
- NUM_IN, 6, number of input operands; legal range 3..8, elaboration error otherwise.
- WIDTH, 32, width of every operand and output; all arithmetic is modulo 2^WIDTH.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- FINAL_ADD, 1, when 1 appends a carry-propagate stage that drives result_o.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  synchronous kill of all in-flight operations
- in_valid_i  in  1  operand set valid
- in_ready_o  out  1  tree can accept an operand set this cycle
- ops_i  in  NUM_IN*WIDTH  packed operands; operand k is at bits [k*WIDTH +: WIDTH]
- in_tag_i  in  TAG_W  sideband tag
- out_valid_o  out  1  output valid
- out_ready_i  in  1  downstream accepts output
- sum_o  out  WIDTH  redundant sum
- carry_o  out  WIDTH  redundant carry, already weighted (shifted left 1 inside the tree)
- result_o  out  WIDTH  sum_o+carry_o mod 2^WIDTH; tied to 0 when FINAL_ADD=0
- out_tag_o  out  TAG_W  tag of the operation on the outputs

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Level rule: with n operands at a level, floor(n/3) triples become 2 operands each and the remaining n mod 3 pass through. So n' = 2*floor(n/3) + (n mod 3), repeated until n = 2.
- Level count L by NUM_IN: 3→1, 4→2, 5→3, 6→3, 7→4, 8→4.
- 3:2 cell, bitwise: s = a^b^c; cy = maj(a,b,c) shifted left 1, LSB = 0, MSB dropped.
- Level ordering: lowest-index operands are grouped first; pass-through operands follow the compressor outputs in index order.
- Pipeline depth: S = L + FINAL_ADD stages. Each stage holds a valid bit, its operand vector and the tag.
- Latency: an accepted operand set appears on the outputs exactly S cycles after the acceptance edge, given no stall.
- Throughput: 1 operation per cycle when out_ready_i = 1.
- Advance rule: stage i loads from stage i-1 when (!valid[i] || advance[i+1]). The last stage advances when (!out_valid_o || out_ready_i).
- in_ready_o = !valid[0] || advance[1]. It is combinational from downstream state; it does not depend on in_valid_i.
- A stage that is not loading holds its data and valid bit. Bubbles collapse: an empty stage always loads.
- out_valid_o = valid[S-1]. sum_o, carry_o, result_o and out_tag_o are stable while out_valid_o=1 and out_ready_i=0.
- Full condition: S valid entries with out_ready_i=0 → in_ready_o=0. Nothing is lost; an offered input stays pending.
- Simultaneous accept and emit when full with out_ready_i=1: all stages shift and in_ready_o=1.
- flush_i=1: all valid bits clear on the next edge. An input presented in the same cycle is discarded. in_ready_o behaves per the normal rule, but nothing is loaded. Data registers are not cleared.
- Reset (rst_n=0 at an edge): all valid bits = 0, all data and tag registers = 0. Hence in_ready_o=1, out_valid_o=0, sum_o/carry_o/result_o/out_tag_o = 0.
- Reset mid-operation drops every in-flight entry. Reset has priority over flush.
- Invariant: sum_o + carry_o ≡ Σ ops_i[k] (mod 2^WIDTH) for every emitted operation.
- Signed and unsigned operands give identical bit results (two's complement wrap).
- Ordering: operations emerge strictly in acceptance order with their tag.
- No X propagation from invalid stages is allowed to affect valid ones.

Test Plan:
- Basic sum: NUM_IN=6, WIDTH=32, FINAL_ADD=1; ops={1,2,3,4,5,6}, tag=0xA → out_valid_o exactly 4 cycles later, result_o=21, sum_o+carry_o=21, out_tag_o=0xA.
- Wrap-around: six operands all 0xFFFFFFFF → result_o=0xFFFFFFFA. Also ops={0x80000000,0x80000000,0,0,0,0} → result_o=0.
- Streaming: 10 back-to-back operations with out_ready_i=1 and op i = {i,0,0,0,0,0} → 10 consecutive out_valid_o cycles, results 0..9 in order, in_ready_o never low.
- Backpressure: out_ready_i=0, feed 5 ops → the first 4 are accepted, in_ready_o=0 while the 5th is offered, and outputs stay stable. Raise out_ready_i → results drain in order, the 5th is accepted the same cycle, and no loss or duplication occurs.
- Flush: 3 ops in flight, assert flush_i for 1 cycle with in_valid_i=1 → no out_valid_o in the following 5 cycles. The next op accepted afterwards emits correctly after 4 cycles.
- Reset and config sweep: rst_n=0 with 2 ops in flight → next cycle out_valid_o=0, in_ready_o=1, all outputs 0. Repeat the random-operand invariant check for NUM_IN=3,4,5,7,8 and for FINAL_ADD=0, with latencies 1,2,3,4,4.
